// File: rtl/simd_alu_pipe.sv
// Two-stage SIMD add/sub/select unit with per-lane wrap or saturating arithmetic,
// valid/ready flow control, per-lane overflow flags and a sticky overflow bit.
module simd_alu_pipe #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [1:0]     size,
  input  logic [1:0]     sat,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   Y,
  output logic [W/8-1:0] flags,
  input  logic           clr_sticky,
  output logic           sticky_ovf
);

  localparam int unsigned NB    = W / 8;
  localparam int unsigned NbLog = $clog2(NB);
  // Largest encodable lane-size exponent that still fits in W.
  localparam logic [1:0]  MaxLog = (NbLog > 3) ? 2'd3 : 2'(NbLog);

  logic          s1_valid;
  logic [W-1:0]  s1_sum, d_sum;
  logic [NB-1:0] s1_cout, d_cout, s1_sub, d_sub, s1_amsb, d_amsb, s1_bmsb, d_bmsb;
  logic [1:0]    s1_sat, s1_log, lb_log;
  logic          s1_sel, d_sel;
  logic [W-1:0]  y_d;
  logic [NB-1:0] f_d;
  logic          s2_adv, sticky_d;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign lb_log   = (size > MaxLog) ? MaxLog : size;
  assign d_sel    = (op == 3'd4) || (op == 3'd5);

  // Byte-sliced adder; the carry chain restarts at every lane boundary.
  always_comb begin : stage1
    int unsigned lmask;
    logic        carry, sub, cin, lane_odd;
    logic [7:0]  beff;
    logic [8:0]  s9;
    lmask    = (32'd1 << lb_log) - 32'd1;
    carry    = 1'b0;
    sub      = 1'b0;
    cin      = 1'b0;
    lane_odd = 1'b0;
    beff     = '0;
    s9       = '0;
    d_sum    = '0;
    d_cout   = '0;
    d_sub    = '0;
    d_amsb   = '0;
    d_bmsb   = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      lane_odd = ((k >> lb_log) & 32'd1) != 32'd0;
      case (op)
        3'd1:    sub = 1'b1;
        3'd2:    sub = lane_odd;
        3'd3:    sub = !lane_odd;
        default: sub = 1'b0;
      endcase
      beff           = sub ? ~B[8*k +: 8] : B[8*k +: 8];
      cin            = ((k & lmask) == 32'd0) ? sub : carry;
      s9             = {1'b0, A[8*k +: 8]} + {1'b0, beff} + {8'd0, cin};
      carry          = s9[8];
      d_sum[8*k +: 8] = s9[7:0];
      d_cout[k]      = s9[8];
      d_sub[k]       = sub;
      d_amsb[k]      = A[8*k+7];
      d_bmsb[k]      = beff[7];
    end
    if (op == 3'd4) d_sum = A;
    if (op == 3'd5) d_sum = B;
  end

  // Overflow is judged from the lane's top byte and applied to every byte of the lane.
  always_comb begin : stage2
    int unsigned lmask, t;
    logic        top, ovf_u, ovf_s, ovf;
    logic [7:0]  sb;
    lmask = (32'd1 << s1_log) - 32'd1;
    t     = 0;
    top   = 1'b0;
    ovf_u = 1'b0;
    ovf_s = 1'b0;
    ovf   = 1'b0;
    sb    = '0;
    y_d   = s1_sum;
    f_d   = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      t     = k | lmask;
      top   = (k == t);
      ovf_u = s1_sub[t] ? !s1_cout[t] : s1_cout[t];
      ovf_s = (s1_amsb[t] == s1_bmsb[t]) && (s1_sum[8*t+7] != s1_amsb[t]);
      ovf   = ((s1_sat == 2'b10) ? ovf_s : ovf_u) && !s1_sel;
      sb    = s1_sum[8*k +: 8];
      if (ovf) begin
        if (s1_sat == 2'b01) begin
          sb = s1_sub[t] ? 8'h00 : 8'hFF;
        end else if (s1_sat == 2'b10) begin
          sb = s1_amsb[t] ? (top ? 8'h80 : 8'h00) : (top ? 8'h7F : 8'hFF);
        end
      end
      y_d[8*k +: 8] = sb;
      f_d[k]        = top && ovf;
    end
  end

  always_comb begin
    sticky_d = clr_sticky ? 1'b0 : sticky_ovf;
    if (out_valid && out_ready && (|flags)) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      s1_sum     <= '0;
      s1_cout    <= '0;
      s1_sub     <= '0;
      s1_amsb    <= '0;
      s1_bmsb    <= '0;
      s1_sat     <= '0;
      s1_log     <= '0;
      s1_sel     <= 1'b0;
      out_valid  <= 1'b0;
      Y          <= '0;
      flags      <= '0;
      sticky_ovf <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_sum  <= d_sum;
        s1_cout <= d_cout;
        s1_sub  <= d_sub;
        s1_amsb <= d_amsb;
        s1_bmsb <= d_bmsb;
        s1_sat  <= sat;
        s1_log  <= lb_log;
        s1_sel  <= d_sel;
      end
      if (s2_adv) out_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        Y     <= y_d;
        flags <= f_d;
      end
      sticky_ovf <= sticky_d;
    end
  end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Self-checking bench for simd_alu_pipe (W=32): vector table through a scoreboard,
// plus hand-written latency, backpressure, sticky and reset sequences.
module tb_simd_alu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [1:0]  size = '0;
  logic [1:0]  sat = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] Y;
  logic [3:0]  flags;
  logic        clr_sticky = 1'b0;
  logic        sticky_ovf;

  logic [31:0] exp_y = '0;
  logic [3:0]  exp_f = '0;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [1:0]  sat;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [3:0]  f;
  } vec_t;

  typedef struct packed {
    logic [31:0] y;
    logic [3:0]  f;
  } res_t;

  vec_t tab[15];
  res_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  simd_alu_pipe #(.W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .size       (size),
    .sat        (sat),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Y          (Y),
    .flags      (flags),
    .clr_sticky (clr_sticky),
    .sticky_ovf (sticky_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Handshake signals are stable at the falling edge; beats there complete at the next rise.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected output", 32'd1, 32'd0);
        end else begin
          res_t r;
          r = q.pop_front();
          check("Y", Y, r.y);
          check("flags", {28'd0, flags}, {28'd0, r.f});
        end
      end
      if (in_valid && in_ready) q.push_back({exp_y, exp_f});
    end
  end

  task automatic set_in(input vec_t v);
    op = v.op; size = v.size; sat = v.sat; A = v.a; B = v.b;
    exp_y = v.y; exp_f = v.f;
    in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    int   n;
    logic acc;
    set_in(v);
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    check("accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", q.size(), 32'd0);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_valid wait", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    vec_t v;
    tab[0]  = '{3'd0, 2'd0, 2'd0, 32'h01FF7F80, 32'h01010101, 32'h02008081, 4'b0100};
    tab[1]  = '{3'd0, 2'd0, 2'd2, 32'h01FF7F80, 32'h01010101, 32'h02007F81, 4'b0010};
    tab[2]  = '{3'd1, 2'd1, 2'd1, 32'h00050010, 32'h00060001, 32'h0000000F, 4'b1000};
    tab[3]  = '{3'd2, 2'd1, 2'd0, 32'h00100010, 32'h00010001, 32'h000F0011, 4'b0000};
    tab[4]  = '{3'd5, 2'd1, 2'd0, 32'h00100010, 32'h00010001, 32'h00010001, 4'b0000};
    tab[5]  = '{3'd4, 2'd0, 2'd1, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 4'b0000};
    tab[6]  = '{3'd0, 2'd0, 2'd1, 32'hFF801020, 32'h02900101, 32'hFFFF1121, 4'b1100};
    tab[7]  = '{3'd1, 2'd2, 2'd2, 32'h80000000, 32'h00000001, 32'h80000000, 4'b1000};
    tab[8]  = '{3'd1, 2'd2, 2'd0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000};
    tab[9]  = '{3'd3, 2'd0, 2'd2, 32'h7F800510, 32'hFF010601, 32'h7E800B0F, 4'b0100};
    tab[10] = '{3'd0, 2'd3, 2'd1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 4'b1000};
    tab[11] = '{3'd0, 2'd3, 2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000};
    tab[12] = '{3'd7, 2'd0, 2'd0, 32'h01020304, 32'h10203040, 32'h11223344, 4'b0000};
    tab[13] = '{3'd2, 2'd0, 2'd1, 32'h05050505, 32'h06060606, 32'h000B000B, 4'b1010};
    tab[14] = '{3'd1, 2'd1, 2'd2, 32'h80007FFF, 32'h0001FFFF, 32'h80007FFF, 4'b1010};

    // Reset state
    #12;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst sticky", {31'd0, sticky_ovf}, 32'd0);
    check("rst Y", Y, 32'd0);
    check("rst flags", {28'd0, flags}, 32'd0);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", {31'd0, in_ready}, 32'd1);

    // Two-cycle latency on a lone operation
    send(tab[0]);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency 1 cycle", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("latency 2 cycles", {31'd0, out_valid}, 32'd1);
    drain();

    // Remaining table back to back
    for (int i = 1; i < 15; i++) send(tab[i]);
    in_valid = 1'b0;
    drain();
    check("sticky set", {31'd0, sticky_ovf}, 32'd1);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("sticky cleared", {31'd0, sticky_ovf}, 32'd0);

    // Flagged beat consumed in the same cycle as a clear: set wins
    out_ready = 1'b0;
    send(tab[8]);
    in_valid = 1'b0;
    wait_out();
    out_ready  = 1'b1;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("sticky set beats clear", {31'd0, sticky_ovf}, 32'd1);
    drain();

    // Backpressure: two accepts fill the pipe, the third stalls
    out_ready = 1'b0;
    v = '{3'd0, 2'd2, 2'd0, 32'd1, 32'd1, 32'd2, 4'b0000};
    send(v);
    v = '{3'd0, 2'd2, 2'd0, 32'd2, 32'd2, 32'd4, 4'b0000};
    send(v);
    v = '{3'd0, 2'd2, 2'd0, 32'd3, 32'd3, 32'd6, 4'b0000};
    set_in(v);
    @(negedge clk);
    check("bp in_ready", {31'd0, in_ready}, 32'd0);
    check("bp out_valid", {31'd0, out_valid}, 32'd1);
    check("bp Y", Y, 32'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp Y held", Y, 32'd2);
    check("bp in_ready held", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain beat 1", Y, 32'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("drain beat 2 valid", {31'd0, out_valid}, 32'd1);
    check("drain beat 2", Y, 32'd4);
    @(posedge clk); #1;
    @(negedge clk);
    check("drain beat 3 valid", {31'd0, out_valid}, 32'd1);
    check("drain beat 3", Y, 32'd6);
    drain();

    // Asynchronous reset with two operations in flight
    out_ready = 1'b0;
    send(tab[8]);
    send(tab[2]);
    in_valid = 1'b0;
    check("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
    check("pre-reset sticky", {31'd0, sticky_ovf}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async rst out_valid", {31'd0, out_valid}, 32'd0);
    check("async rst sticky", {31'd0, sticky_ovf}, 32'd0);
    check("async rst Y", Y, 32'd0);
    q.delete();
    #3 rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", {31'd0, in_ready}, 32'd1);
    v = '{3'd0, 2'd2, 2'd0, 32'd5, 32'd7, 32'd12, 4'b0000};
    send(v);
    in_valid = 1'b0;
    drain();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("no stale output", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
